pipelined_adder_nbit: RTL and testbench
=======================================

Name: pipelined_adder_nbit

Overview:
- Parametrised, pipelined, valid/ready-handshaked integer adder that generalises the hierarchical 8/16/32-bit adder tree.
- The WIDTH-bit addition is split into NUM_STAGES equal chunks of width CHUNK = WIDTH/NUM_STAGES.
- Each chunk adds in its own pipeline stage and registers its carry forward into the next stage.
- Sits in the arithmetic datapath; is a flatten-regression target for hierarchical, parametrised, sequential logic.

Parameters:
- WIDTH, 32, operand and sum width in bits. Must be divisible by NUM_STAGES.
- NUM_STAGES, 4, number of pipeline stages; one chunk is added per stage (1..WIDTH).
- SIGNED, 0, 1 = two's-complement overflow detection; 0 = unsigned carry-out only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to chunk 0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow when SIGNED=1; tied 0 when SIGNED=0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear, out_valid=0, sum=0, cout=0, ovf=0, all carry and partial registers clear. in_ready=1 once reset deasserts.
- Transfer rule: a beat transfers on in_valid&&in_ready (input side) and on out_valid&&out_ready (output side).
- Stage k (0..NUM_STAGES-1):
  - Adds a[k*CHUNK +: CHUNK] + b[same] + carry_k, where carry_0 = cin.
  - Stores the CHUNK-bit result and carry_{k+1}.
  - Carries the not-yet-added upper operand chunks and the already-completed lower sum chunks forward.
- Latency: NUM_STAGES cycles from input acceptance to out_valid, with no stalls. Throughput is one result per cycle.
- Pipeline valid bits:
  - Each stage holds a valid bit.
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances when out_ready or when out_valid=0.
  - in_ready = stage-0 register empty or advancing. It is combinational from out_ready through the stage chain; no skid buffer.
- Backpressure:
  - With out_ready=0 and the pipe full, in_ready=0.
  - sum, cout and ovf hold stable while out_valid&&!out_ready.
  - No beat is lost or duplicated.
- Bubbles: gaps in in_valid propagate as invalid stages. out_valid deasserts for exactly those cycles.
- Outputs on empty pipe: sum, cout and ovf hold their last value when out_valid=0; they are not cleared.
- cout = carry out of the final stage.
- ovf (SIGNED=1) = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]). The operand MSBs are carried to the last stage for this check.
- Wrap-around: full-scale operands (all ones + all ones + cin=1) give sum = all ones, cout=1.
- Degenerate case NUM_STAGES=1: a single registered full-width adder with the same handshake rules.
- Reset mid-operation: all in-flight beats are discarded. No out_valid appears for them after reset release.

Test Plan:
- Directed add, WIDTH=32, NUM_STAGES=4, out_ready=1: a=0x0000FFFF, b=0x00000001, cin=0 -> after 4 cycles out_valid=1, sum=0x00010000, cout=0. This exercises the carry crossing the chunk boundary.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1. Then a=b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1.
- Signed overflow, SIGNED=1: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, ovf=1. Then a=0x80000000, b=0xFFFFFFFF -> sum=0x7FFFFFFF, ovf=1, cout=1. Then a=5, b=-3 -> sum=2, ovf=0.
- Backpressure: stream 8 consecutive beats (a=i, b=100*i). Hold out_ready=0 for 6 cycles starting at cycle 3 -> in_ready falls once 4 beats are buffered, outputs hold stable, and all 8 results are delivered in order with sum=101*i and no loss.
- Reset mid-stream: pull rst_n low while 3 beats are in flight -> out_valid=0 and sum=0 immediately (asynchronously). After release the first output is for the first beat accepted after reset.
- Parameter sweep: random operands at WIDTH=8/NUM_STAGES=1, WIDTH=16/NUM_STAGES=2 and WIDTH=64/NUM_STAGES=8, with random in_valid/out_ready toggling -> results match a scoreboard model, and latency equals NUM_STAGES when unstalled.

Source files
------------

// File: rtl/pipelined_adder_nbit.sv
// Pipelined valid/ready integer adder: WIDTH bits split into NUM_STAGES chunks,
// one chunk summed per stage with the carry registered into the next stage.
module pipelined_adder_nbit #(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 4,
    parameter bit SIGNED     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / NUM_STAGES;
    localparam int MSB   = WIDTH - 1;

    logic [NUM_STAGES-1:0] vld_p;
    logic [NUM_STAGES-1:0] cry_p;
    logic [WIDTH-1:0]      sum_p [NUM_STAGES];
    logic [WIDTH-1:0]      a_p   [NUM_STAGES];
    logic [WIDTH-1:0]      b_p   [NUM_STAGES];

    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] src_v;
    logic [NUM_STAGES-1:0] src_c;
    logic [NUM_STAGES-1:0] nxt_c;
    logic [WIDTH-1:0]      src_a [NUM_STAGES];
    logic [WIDTH-1:0]      src_b [NUM_STAGES];
    logic [WIDTH-1:0]      src_s [NUM_STAGES];
    logic [WIDTH-1:0]      nxt_s [NUM_STAGES];

    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    function automatic logic signed_ovf(input logic signed [WIDTH-1:0] x,
                                        input logic signed [WIDTH-1:0] y,
                                        input logic signed [WIDTH-1:0] s);
        return (x[MSB] == y[MSB]) && (s[MSB] != x[MSB]);
    endfunction

    // A stage may load when it, or any stage downstream of it, is empty or the sink takes a beat.
    always_comb begin
        logic acc;
        adv = '0;
        acc = out_ready;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            acc    = acc || !vld_p[k];
            adv[k] = acc;
        end
    end

    always_comb begin
        logic [CHUNK:0] res;
        res   = '0;
        src_v = '0;
        src_c = '0;
        nxt_c = '0;
        src_a = '{default: '0};
        src_b = '{default: '0};
        src_s = '{default: '0};
        nxt_s = '{default: '0};
        src_v[0] = in_valid;
        src_c[0] = cin;
        src_a[0] = a;
        src_b[0] = b;
        for (int k = 1; k < NUM_STAGES; k++) begin
            src_v[k] = vld_p[k-1];
            src_c[k] = cry_p[k-1];
            src_a[k] = a_p[k-1];
            src_b[k] = b_p[k-1];
            src_s[k] = sum_p[k-1];
        end
        for (int k = 0; k < NUM_STAGES; k++) begin
            res = add_chunk(src_a[k][k*CHUNK +: CHUNK], src_b[k][k*CHUNK +: CHUNK], src_c[k]);
            nxt_s[k] = src_s[k];
            nxt_s[k][k*CHUNK +: CHUNK] = res[CHUNK-1:0];
            nxt_c[k] = res[CHUNK];
        end
    end

    // Stage registers: data only loads with a valid beat so idle outputs keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            cry_p <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                sum_p[k] <= '0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (adv[k]) begin
                    vld_p[k] <= src_v[k];
                end
                if (adv[k] && src_v[k]) begin
                    sum_p[k] <= nxt_s[k];
                    cry_p[k] <= nxt_c[k];
                    a_p[k]   <= src_a[k];
                    b_p[k]   <= src_b[k];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_p[NUM_STAGES-1];
    assign sum       = sum_p[NUM_STAGES-1];
    assign cout      = cry_p[NUM_STAGES-1];
    assign ovf       = SIGNED ? signed_ovf(a_p[NUM_STAGES-1], b_p[NUM_STAGES-1],
                                           sum_p[NUM_STAGES-1]) : 1'b0;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Bench for pipelined_adder_nbit: directed 32-bit cases, backpressure, mid-stream reset,
// and a randomized handshake sweep over three geometries against a plain-arithmetic model.
module tb_pipelined_adder_nbit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] a32, b32, sum32;
    logic        cin32, iv32, ir32, ov32, or32, cout32, ovf32;

    pipelined_adder_nbit #(.WIDTH(32), .NUM_STAGES(4), .SIGNED(1'b1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .out_valid(ov32), .out_ready(or32), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    int          sel;
    logic [63:0] sw_a, sw_b;
    logic        sw_cin, sw_iv, sw_or;
    logic [7:0]  s8_sum;
    logic [15:0] s16_sum;
    logic [63:0] s64_sum;
    logic        s8_ir, s8_ov, s8_cout, s8_ovf;
    logic        s16_ir, s16_ov, s16_cout, s16_ovf;
    logic        s64_ir, s64_ov, s64_cout, s64_ovf;
    logic [63:0] obs_sum;
    logic        obs_ir, obs_ov, obs_cout, obs_ovf;

    pipelined_adder_nbit #(.WIDTH(8), .NUM_STAGES(1), .SIGNED(1'b0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_iv && sel == 0), .in_ready(s8_ir),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .out_valid(s8_ov), .out_ready(sw_or),
        .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf)
    );
    pipelined_adder_nbit #(.WIDTH(16), .NUM_STAGES(2), .SIGNED(1'b1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_iv && sel == 1), .in_ready(s16_ir),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .out_valid(s16_ov), .out_ready(sw_or),
        .sum(s16_sum), .cout(s16_cout), .ovf(s16_ovf)
    );
    pipelined_adder_nbit #(.WIDTH(64), .NUM_STAGES(8), .SIGNED(1'b0)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_iv && sel == 2), .in_ready(s64_ir),
        .a(sw_a), .b(sw_b), .cin(sw_cin), .out_valid(s64_ov), .out_ready(sw_or),
        .sum(s64_sum), .cout(s64_cout), .ovf(s64_ovf)
    );

    always_comb begin
        obs_ir = 1'b0; obs_ov = 1'b0; obs_sum = '0; obs_cout = 1'b0; obs_ovf = 1'b0;
        case (sel)
            0: begin
                obs_ir = s8_ir; obs_ov = s8_ov; obs_sum = {56'd0, s8_sum};
                obs_cout = s8_cout; obs_ovf = s8_ovf;
            end
            1: begin
                obs_ir = s16_ir; obs_ov = s16_ov; obs_sum = {48'd0, s16_sum};
                obs_cout = s16_cout; obs_ovf = s16_ovf;
            end
            default: begin
                obs_ir = s64_ir; obs_ov = s64_ov; obs_sum = s64_sum;
                obs_cout = s64_cout; obs_ovf = s64_ovf;
            end
        endcase
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference: {ovf, cout, sum} of a w-bit add from plain wide arithmetic.
    function automatic logic [65:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                            input logic c, input int w, input bit sg);
        logic [63:0] m, s;
        logic [64:0] full;
        logic        co, ov, xm, ym, sm;
        m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        full = {1'b0, x & m} + {1'b0, y & m} + 65'(c);
        s    = full[63:0] & m;
        co   = 1'(full >> w);
        xm   = 1'(x >> (w - 1));
        ym   = 1'(y >> (w - 1));
        sm   = 1'(s >> (w - 1));
        ov   = sg && (xm == ym) && (sm != xm);
        return {ov, co, s};
    endfunction

    task automatic beat32(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tc, input logic [31:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        a32 = ta; b32 = tb_; cin32 = tc; iv32 = 1'b1; or32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        n = 1;
        while (!ov32 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 128'(n), 128'(4));
        check({tag, "_sum"}, 128'(sum32), 128'(es));
        check({tag, "_cout"}, 128'(cout32), 128'(ec));
        check({tag, "_ovf"}, 128'(ovf32), 128'(eo));
        @(posedge clk); #1;
    endtask

    task automatic run_sweep(input int w, input int ns, input bit sg, input int nbeats);
        logic [65:0] q[$];
        logic [65:0] want, held, obs;
        bit          stalled;
        int          sent, n;
        @(negedge clk);
        sw_or = 1'b1; sw_iv = 1'b1;
        sw_a = {$urandom(), $urandom()}; sw_b = {$urandom(), $urandom()};
        sw_cin = 1'($urandom_range(0, 1));
        want = ref_add(sw_a, sw_b, sw_cin, w, sg);
        @(posedge clk); #1;
        sw_iv = 1'b0;
        n = 1;
        while (!obs_ov && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("w%0d_lat", w), 128'(n), 128'(ns));
        check($sformatf("w%0d_first", w), 128'({obs_ovf, obs_cout, obs_sum}), 128'(want));
        @(posedge clk); #1;
        sent = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 2000 && (sent < nbeats || q.size() > 0); cyc++) begin
            @(negedge clk);
            sw_iv  = (sent < nbeats) && ($urandom_range(0, 3) != 0);
            sw_or  = ($urandom_range(0, 3) != 0);
            sw_a   = {$urandom(), $urandom()};
            sw_b   = {$urandom(), $urandom()};
            sw_cin = 1'($urandom_range(0, 1));
            #1;
            obs = {obs_ovf, obs_cout, obs_sum};
            check($sformatf("w%0d_in_ready", w), 128'(obs_ir), 128'((q.size() < ns) || sw_or));
            if (stalled) check($sformatf("w%0d_hold", w), 128'({obs_ov, obs}), 128'({1'b1, held}));
            stalled = obs_ov && !sw_or;
            held    = obs;
            if (obs_ov && sw_or) begin
                if (q.size() == 0) begin
                    check($sformatf("w%0d_spurious", w), 128'(obs_ov), 128'(0));
                end else begin
                    want = q.pop_front();
                    check($sformatf("w%0d_result", w), 128'(obs), 128'(want));
                end
            end
            if (sw_iv && obs_ir) begin
                q.push_back(ref_add(sw_a, sw_b, sw_cin, w, sg));
                sent++;
            end
        end
        check($sformatf("w%0d_drained", w), 128'({sent, 32'(q.size())}), 128'({nbeats, 32'd0}));
        sw_iv = 1'b0; sw_or = 1'b1;
    endtask

    initial begin
        int          sent, got, low_cnt;
        bit          stalled;
        logic [34:0] held;
        rst_n = 1'b0;
        a32 = '0; b32 = '0; cin32 = 1'b0; iv32 = 1'b0; or32 = 1'b1;
        sel = 0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_iv = 1'b0; sw_or = 1'b1;

        #12;
        check("rst_out_valid", 128'(ov32), 128'(0));
        check("rst_sum", 128'(sum32), 128'(0));
        check("rst_cout_ovf", 128'({cout32, ovf32}), 128'(0));
        check("rst_sweep_valid", 128'({s8_ov, s16_ov, s64_ov}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 128'(ir32), 128'(1));

        beat32("chunk_carry", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);
        beat32("ripple_zero", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
        beat32("full_scale",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        beat32("ovf_pos",     32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        beat32("ovf_neg",     32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
        beat32("no_ovf",      32'h00000005, 32'hFFFFFFFD, 1'b0, 32'h00000002, 1'b1, 1'b0);

        // Backpressure: 8 beats, sink stalled for cycles 3..8.
        sent = 0; got = 0; low_cnt = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            or32 = !(cyc >= 3 && cyc < 9);
            iv32 = (sent < 8);
            a32 = 32'(sent); b32 = 32'(100 * sent); cin32 = 1'b0;
            #1;
            check("bp_in_ready", 128'(ir32), 128'((sent - got < 4) || or32));
            if (!ir32) low_cnt++;
            if (stalled) check("bp_hold", 128'({ov32, sum32, cout32, ovf32}), 128'(held));
            stalled = ov32 && !or32;
            held    = {ov32, sum32, cout32, ovf32};
            if (ov32 && or32) begin
                check("bp_sum", 128'(sum32), 128'(101 * got));
                got++;
            end
            if (iv32 && ir32) sent++;
        end
        check("bp_delivered", 128'(got), 128'(8));
        check("bp_ready_low_cycles", 128'(low_cnt), 128'(5));
        iv32 = 1'b0; or32 = 1'b1;

        // Mid-stream reset with three beats in flight.
        @(negedge clk);
        iv32 = 1'b1; a32 = 32'd1; b32 = 32'd2;
        @(posedge clk); #1; a32 = 32'd3;
        @(posedge clk); #1; a32 = 32'd5;
        @(posedge clk); #1; iv32 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(ov32), 128'(0));
        check("midrst_sum", 128'(sum32), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 128'(ir32), 128'(1));
        beat32("post_rst", 32'h00001234, 32'h00001000, 1'b0, 32'h00002234, 1'b0, 1'b0);

        sel = 0; run_sweep(8, 1, 1'b0, 80);
        sel = 1; run_sweep(16, 2, 1'b1, 80);
        sel = 2; run_sweep(64, 8, 1'b0, 80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
